// File: rtl/chronos_pkg.sv
// Shared types for the tile task path: task word and per-unit slot states.
package chronos;

    localparam int unsigned TQ_WIDTH = 32;

    typedef logic [TQ_WIDTH-1:0] task_t;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_START = 2'd1,
        SLOT_RUN   = 2'd2
    } slot_state_t;

endpackage

// File: rtl/task_unit_dispatcher_if.sv
// AXI-Stream-like task handshake between the tile task queue and the dispatcher.
interface task_unit_dispatcher_if;

    chronos::task_t tdata;
    logic           tvalid;
    logic           tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);

endinterface

// File: rtl/task_unit_dispatcher_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after the pointer.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any_gnt
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;

    // Scan N positions starting at the pointer, wrapping at N.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!any_gnt && req[IW'(cand)]) begin
                any_gnt          = 1'b1;
                gnt_idx          = IW'(cand);
                gnt[IW'(cand)]   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && any_gnt) begin
            ptr_d = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/task_unit_dispatcher.sv
// Dispatches queued tasks round-robin onto a pool of ap_ctrl task units and
// tracks in-flight / dispatched / completed counts.
module task_unit_dispatcher
    import chronos::*;
#(
    parameter  int unsigned N_CORES   = 4,
    parameter  int unsigned CNT_WIDTH = 32,
    localparam int unsigned IFW       = $clog2(N_CORES + 1),
    localparam int unsigned IW        = $clog2(N_CORES)
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    task_unit_dispatcher_if.slave         s_task,
    input  logic                          enable,
    output logic [N_CORES-1:0]            core_ap_start,
    output logic [N_CORES*TQ_WIDTH-1:0]   core_task_in,
    input  logic [N_CORES-1:0]            core_ap_ready,
    input  logic [N_CORES-1:0]            core_ap_done,
    output logic [IFW-1:0]                inflight,
    output logic                          all_idle,
    output logic [CNT_WIDTH-1:0]          n_dispatched,
    output logic [CNT_WIDTH-1:0]          n_completed,
    output logic                          err_spurious_done
);

    logic [N_CORES-1:0]   idle_c;
    logic [N_CORES-1:0]   honoured_c;
    logic [N_CORES-1:0]   spurious_c;
    logic [N_CORES-1:0]   gnt;
    logic [IW-1:0]        gnt_idx_unused;
    logic                 any_gnt;
    logic                 transfer;

    logic                 alive_q;
    logic [IFW-1:0]       inflight_q, inflight_d;
    logic [IFW-1:0]       done_cnt;
    logic                 all_idle_q, all_idle_d;
    logic [CNT_WIDTH-1:0] n_disp_q, n_disp_d;
    logic [CNT_WIDTH-1:0] n_comp_q, n_comp_d;
    logic                 err_q, err_d;

    // Ready depends only on registered slot state; alive_q keeps it low in reset.
    assign s_task.tready = alive_q & enable & any_gnt;
    assign transfer      = s_task.tvalid & s_task.tready;

    rr_arbiter #(.N(N_CORES)) u_arb (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .req     (idle_c),
        .advance (transfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx_unused),
        .any_gnt (any_gnt)
    );

    for (genvar i = 0; i < N_CORES; i++) begin : g_slot
        slot_state_t slot_q, slot_d;
        task_t       task_q, task_d;
        logic        start_q, start_d;
        logic        hon_c;

        always_comb begin
            slot_d = slot_q;
            task_d = task_q;
            hon_c  = 1'b0;
            case (slot_q)
                SLOT_IDLE: begin
                    if (transfer && gnt[i]) begin
                        slot_d = SLOT_START;
                        task_d = s_task.tdata;
                    end
                end
                SLOT_START: begin
                    if (core_ap_ready[i]) begin
                        slot_d = SLOT_RUN;
                    end
                end
                SLOT_RUN: begin
                    if (core_ap_done[i]) begin
                        slot_d = SLOT_IDLE;
                        hon_c  = 1'b1;
                    end
                end
                default: slot_d = SLOT_IDLE;
            endcase
            start_d = (slot_d == SLOT_START);
        end

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                slot_q  <= SLOT_IDLE;
                task_q  <= '0;
                start_q <= 1'b0;
            end else begin
                slot_q  <= slot_d;
                task_q  <= task_d;
                start_q <= start_d;
            end
        end

        assign idle_c[i]      = (slot_q == SLOT_IDLE);
        assign honoured_c[i]  = hon_c;
        assign spurious_c[i]  = core_ap_done[i] && (slot_q != SLOT_RUN);
        assign core_ap_start[i] = start_q;
        assign core_task_in[i*TQ_WIDTH +: TQ_WIDTH] = task_q;
    end

    // Bookkeeping: all dones honoured in a cycle are subtracted together.
    always_comb begin
        done_cnt = '0;
        for (int unsigned k = 0; k < N_CORES; k++) begin
            done_cnt = done_cnt + IFW'(honoured_c[k]);
        end
        inflight_d = inflight_q + IFW'(transfer) - done_cnt;
        all_idle_d = (inflight_d == '0);
        n_disp_d   = n_disp_q + CNT_WIDTH'(transfer);
        n_comp_d   = n_comp_q + CNT_WIDTH'(done_cnt);
        err_d      = err_q | (|spurious_c);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            alive_q    <= 1'b0;
            inflight_q <= '0;
            all_idle_q <= 1'b1;
            n_disp_q   <= '0;
            n_comp_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            alive_q    <= 1'b1;
            inflight_q <= inflight_d;
            all_idle_q <= all_idle_d;
            n_disp_q   <= n_disp_d;
            n_comp_q   <= n_comp_d;
            err_q      <= err_d;
        end
    end

    assign inflight          = inflight_q;
    assign all_idle          = all_idle_q;
    assign n_dispatched      = n_disp_q;
    assign n_completed       = n_comp_q;
    assign err_spurious_done = err_q;

endmodule

// File: tb/tb_task_unit_dispatcher.sv
// Directed bench for task_unit_dispatcher with N_CORES=4.
module tb_task_unit_dispatcher;
    import chronos::*;

    localparam int unsigned N   = 4;
    localparam int unsigned CW  = 32;
    localparam int unsigned IFW = $clog2(N + 1);

    logic                  ap_clk = 1'b0;
    logic                  ap_rst_n = 1'b0;
    logic                  enable;
    logic [N-1:0]          core_ap_start;
    logic [N*TQ_WIDTH-1:0] core_task_in;
    logic [N-1:0]          core_ap_ready;
    logic [N-1:0]          core_ap_done;
    logic [IFW-1:0]        inflight;
    logic                  all_idle;
    logic [CW-1:0]         n_dispatched;
    logic [CW-1:0]         n_completed;
    logic                  err_spurious_done;

    int n_checks = 0;
    int n_fail   = 0;

    task_unit_dispatcher_if s_task ();

    always #5 ap_clk = ~ap_clk;

    task_unit_dispatcher #(.N_CORES(N), .CNT_WIDTH(CW)) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (ap_rst_n),
        .s_task            (s_task.slave),
        .enable            (enable),
        .core_ap_start     (core_ap_start),
        .core_task_in      (core_task_in),
        .core_ap_ready     (core_ap_ready),
        .core_ap_done      (core_ap_done),
        .inflight          (inflight),
        .all_idle          (all_idle),
        .n_dispatched      (n_dispatched),
        .n_completed       (n_completed),
        .err_spurious_done (err_spurious_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic task_t slice(input int i);
        return core_task_in[i*TQ_WIDTH +: TQ_WIDTH];
    endfunction

    task automatic do_reset();
        ap_rst_n      = 1'b0;
        enable        = 1'b1;
        s_task.tvalid = 1'b0;
        s_task.tdata  = '0;
        core_ap_ready = '1;
        core_ap_done  = '0;
        repeat (2) step();
        ap_rst_n = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        enable        = 1'b1;
        s_task.tvalid = 1'b0;
        s_task.tdata  = '0;
        core_ap_ready = '1;
        core_ap_done  = '0;
        #12;
        chk("rst_start",    64'(core_ap_start), 64'h0);
        chk("rst_tready",   64'(s_task.tready), 64'h0);
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_all_idle", 64'(all_idle), 64'h1);
        chk("rst_ndisp",    64'(n_dispatched), 64'h0);
        chk("rst_err",      64'(err_spurious_done), 64'h0);

        // Single task through slot 0
        do_reset();
        s_task.tvalid = 1'b1;
        s_task.tdata  = 32'hABCD;
        #1 chk("t1_tready", 64'(s_task.tready), 64'h1);
        step();
        s_task.tvalid = 1'b0;
        chk("t1_start",  64'(core_ap_start), 64'h1);
        chk("t1_task",   64'(slice(0)), 64'hABCD);
        chk("t1_infl",   64'(inflight), 64'h1);
        step();
        chk("t1_start_lo", 64'(core_ap_start), 64'h0);
        chk("t1_infl_run", 64'(inflight), 64'h1);
        repeat (3) step();
        core_ap_done = 4'b0001;
        chk("t1_task_hold", 64'(slice(0)), 64'hABCD);
        chk("t1_infl_done", 64'(inflight), 64'h1);
        step();
        core_ap_done = '0;
        chk("t1_infl_end", 64'(inflight), 64'h0);
        chk("t1_all_idle", 64'(all_idle), 64'h1);
        chk("t1_ndisp",    64'(n_dispatched), 64'h1);
        chk("t1_ncomp",    64'(n_completed), 64'h1);

        // Round-robin fill, then refill the slot freed by a done
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s_task.tvalid = 1'b1;
            s_task.tdata  = 32'h100 + 32'(i);
            #1 chk("rr_tready", 64'(s_task.tready), 64'h1);
            if (i > 0) chk("rr_start", 64'(core_ap_start), 64'(1 << (i - 1)));
            step();
        end
        chk("rr_start3",   64'(core_ap_start), 64'h8);
        #1 chk("rr_full_tready", 64'(s_task.tready), 64'h0);
        chk("rr_infl4",    64'(inflight), 64'h4);
        step();
        core_ap_done = 4'b0100;
        s_task.tdata = 32'h200;
        #1 chk("rr_done_tready", 64'(s_task.tready), 64'h0);
        step();
        core_ap_done = '0;
        #1 chk("rr_free_tready", 64'(s_task.tready), 64'h1);
        step();
        s_task.tvalid = 1'b0;
        chk("rr_refill_start", 64'(core_ap_start), 64'h4);
        chk("rr_refill_task",  64'(slice(2)), 64'h200);
        chk("rr_slot1_task",   64'(slice(1)), 64'h101);
        chk("rr_infl",         64'(inflight), 64'h4);
        chk("rr_ndisp",        64'(n_dispatched), 64'h5);
        chk("rr_ncomp",        64'(n_completed), 64'h1);

        // Transfer to slot 1 in the same cycle as done on slot 0
        do_reset();
        s_task.tvalid = 1'b1;
        s_task.tdata  = 32'h400;
        step();
        s_task.tvalid = 1'b0;
        step();
        s_task.tvalid = 1'b1;
        s_task.tdata  = 32'h401;
        core_ap_done  = 4'b0001;
        #1 chk("sim_tready", 64'(s_task.tready), 64'h1);
        chk("sim_infl_pre",  64'(inflight), 64'h1);
        chk("sim_ndisp_pre", 64'(n_dispatched), 64'h1);
        chk("sim_ncomp_pre", 64'(n_completed), 64'h0);
        step();
        core_ap_done = '0;
        chk("sim_infl",  64'(inflight), 64'h1);
        chk("sim_ndisp", 64'(n_dispatched), 64'h2);
        chk("sim_ncomp", 64'(n_completed), 64'h1);
        chk("sim_start", 64'(core_ap_start), 64'h2);
        chk("sim_task",  64'(slice(1)), 64'h401);

        // Unit 2 withholds ap_ready for 5 cycles after grant
        s_task.tdata  = 32'h3333;
        core_ap_ready = 4'b1011;
        step();
        s_task.tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_start", 64'(core_ap_start[2]), 64'h1);
            chk("stall_task",  64'(slice(2)), 64'h3333);
            step();
        end
        core_ap_ready = '1;
        chk("stall_rdy_start", 64'(core_ap_start[2]), 64'h1);
        step();
        chk("stall_run_start", 64'(core_ap_start[2]), 64'h0);
        chk("stall_infl",      64'(inflight), 64'h2);

        // Spurious done on idle slot 3, then drain with enable low
        core_ap_done = 4'b1000;
        step();
        core_ap_done = '0;
        chk("spur_err",   64'(err_spurious_done), 64'h1);
        chk("spur_ncomp", 64'(n_completed), 64'h1);
        chk("spur_infl",  64'(inflight), 64'h2);
        enable        = 1'b0;
        s_task.tvalid = 1'b1;
        s_task.tdata  = 32'h555;
        #1 chk("en_tready", 64'(s_task.tready), 64'h0);
        step();
        core_ap_done = 4'b0010;
        step();
        core_ap_done = 4'b0100;
        chk("en_infl1", 64'(inflight), 64'h1);
        chk("en_busy",  64'(all_idle), 64'h0);
        step();
        core_ap_done = '0;
        chk("en_infl0",    64'(inflight), 64'h0);
        chk("en_all_idle", 64'(all_idle), 64'h1);
        chk("en_ncomp",    64'(n_completed), 64'h3);
        chk("en_ndisp",    64'(n_dispatched), 64'h3);
        chk("en_err_stk",  64'(err_spurious_done), 64'h1);

        // Async reset between edges with three tasks in flight
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_task.tdata = 32'h600 + 32'(i);
            step();
        end
        s_task.tvalid = 1'b0;
        chk("mid_infl3", 64'(inflight), 64'h3);
        chk("mid_ndisp", 64'(n_dispatched), 64'h6);
        step();
        #2 ap_rst_n = 1'b0;
        #1;
        chk("mid_start",    64'(core_ap_start), 64'h0);
        chk("mid_tready",   64'(s_task.tready), 64'h0);
        chk("mid_infl",     64'(inflight), 64'h0);
        chk("mid_all_idle", 64'(all_idle), 64'h1);
        chk("mid_ndisp0",   64'(n_dispatched), 64'h0);
        chk("mid_ncomp0",   64'(n_completed), 64'h0);
        chk("mid_err",      64'(err_spurious_done), 64'h0);
        step();
        ap_rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
